// File: rtl/watch_pkg.sv
// Shared definitions for the watch time transmitter: ASCII constants,
// message lengths, FSM state types and the two-digit field formatter.
// Optional feature macro: WATCH_TX_CRLF_EN (appends CR LF to each message).
package watch_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int MSG_LEN_BASE = 11;   // "HH:MM:SS.CC"
    localparam int MSG_LEN_CRLF = 13;   // "HH:MM:SS.CC\r\n"

`ifdef WATCH_TX_CRLF_EN
    localparam int MSG_LEN = MSG_LEN_CRLF;
`else
    localparam int MSG_LEN = MSG_LEN_BASE;
`endif

    // Message-level sequencing: LOAD picks the next byte, SEND waits for its frame.
    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_LOAD,
        MSG_SEND
    } msg_state_t;

    // Bit-level sequencing inside one UART frame.
    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_t;

    // Returns {tens_char, units_char}. Tens are found by repeated
    // compare/subtract of 10 so no divider is inferred; nine steps cover 0..99.
    // Values at or above the field limit are shown as "--".
    function automatic logic [15:0] fmt_field(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] rem;
        logic [7:0] tens;
        rem  = v;
        tens = 8'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 8'd1;
            end
        end
        if (v >= vmax) begin
            return {ASCII_DASH, ASCII_DASH};
        end
        return {ASCII_ZERO + tens, ASCII_ZERO + rem};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte: start bit, d0..d7 LSB first, stop bit,
// each held BIT_CLKS clocks. done is high during the final clock of the
// stop bit so the caller can queue the next byte with no extra gap.
module uart_tx_byte
    import watch_pkg::*;
#(
    parameter int BIT_CLKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int              CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BIT_CLKS - 1);

    bit_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Frame FSM: baud counter, bit index and registered line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                BIT_IDLE: begin
                    if (start) begin
                        shift_q <= data;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= BIT_START;
                    end
                end
                BIT_START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= BIT_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= BIT_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= BIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= BIT_IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != BIT_IDLE);
    assign done = (state_q == BIT_STOP) && bit_end;

endmodule

// File: rtl/watch_time_tx.sv
// Snapshots hour/min/sec/centisecond on request and sends "HH:MM:SS.CC"
// over UART 8N1. Optional feature macro: WATCH_TX_CRLF_EN appends CR LF.
module watch_time_tx
    import watch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int MSEC_MAX = 100,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60,
    parameter int HOUR_MAX = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        send,
    input  logic [$clog2(HOUR_MAX)-1:0] hour,
    input  logic [$clog2(MIN_MAX)-1:0]  min,
    input  logic [$clog2(SEC_MAX)-1:0]  sec,
    input  logic [$clog2(MSEC_MAX)-1:0] msec,
    output logic                        tx,
    output logic                        busy,
    output logic                        done
);

    localparam int         BIT_CLKS = CLK_FREQ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    msg_state_t                  state_q;
    logic                        busy_q;
    logic                        done_q;
    logic [3:0]                  idx_q;
    logic [$clog2(HOUR_MAX)-1:0] hour_q;
    logic [$clog2(MIN_MAX)-1:0]  min_q;
    logic [$clog2(SEC_MAX)-1:0]  sec_q;
    logic [$clog2(MSEC_MAX)-1:0] msec_q;

    logic [15:0] hour_chars;
    logic [15:0] min_chars;
    logic [15:0] sec_chars;
    logic [15:0] msec_chars;
    logic [7:0]  cur_byte;
    logic        byte_start;
    logic        byte_busy;
    logic        byte_done;

    assign hour_chars = fmt_field(8'(hour_q), 8'(HOUR_MAX));
    assign min_chars  = fmt_field(8'(min_q),  8'(MIN_MAX));
    assign sec_chars  = fmt_field(8'(sec_q),  8'(SEC_MAX));
    assign msec_chars = fmt_field(8'(msec_q), 8'(MSEC_MAX));

    // Select the message byte for the current index from the snapshot.
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            4'd0:    cur_byte = hour_chars[15:8];
            4'd1:    cur_byte = hour_chars[7:0];
            4'd2:    cur_byte = ASCII_COLON;
            4'd3:    cur_byte = min_chars[15:8];
            4'd4:    cur_byte = min_chars[7:0];
            4'd5:    cur_byte = ASCII_COLON;
            4'd6:    cur_byte = sec_chars[15:8];
            4'd7:    cur_byte = sec_chars[7:0];
            4'd8:    cur_byte = ASCII_DOT;
            4'd9:    cur_byte = msec_chars[15:8];
            4'd10:   cur_byte = msec_chars[7:0];
`ifdef WATCH_TX_CRLF_EN
            4'd11:   cur_byte = ASCII_CR;
            4'd12:   cur_byte = ASCII_LF;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    assign byte_start = (state_q == MSG_LOAD) && !byte_busy;

    // Message FSM: accept/snapshot, walk the byte index, flag completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MSG_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            msec_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MSG_IDLE: begin
                    if (send && !busy_q) begin
                        hour_q  <= hour;
                        min_q   <= min;
                        sec_q   <= sec;
                        msec_q  <= msec;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= MSG_LOAD;
                    end
                end
                MSG_LOAD: begin
                    if (!byte_busy) begin
                        state_q <= MSG_SEND;
                    end
                end
                MSG_SEND: begin
                    if (byte_done) begin
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= MSG_IDLE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= MSG_LOAD;
                        end
                    end
                end
                default: state_q <= MSG_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .BIT_CLKS (BIT_CLKS)
    ) u_tx_byte (
        .clk   (clk),
        .reset (reset),
        .start (byte_start),
        .data  (cur_byte),
        .tx    (tx),
        .busy  (byte_busy),
        .done  (byte_done)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_watch_time_tx.sv
// Self-checking bench for watch_time_tx at CLK_FREQ=16, BAUD=1 (16 clocks/bit).
// A line receiver decodes tx into bytes; a string model built from the
// field rules gives the expected characters. Honors WATCH_TX_CRLF_EN.
module tb_watch_time_tx;

`ifdef WATCH_TX_CRLF_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 11;
`endif
    localparam int BITC      = 16;
    localparam int BYTE_CLKS = 10 * BITC + 1;

    logic       clk;
    logic       reset;
    logic       send;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    logic [9:0] raw_q[$];
    int         start_cyc_q[$];
    int         frame_err = 0;

    bit         mon_active = 0;
    int         mon_cnt    = 0;
    logic [9:0] mon_bits   = '0;

    watch_time_tx #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .MSEC_MAX (100),
        .SEC_MAX  (60),
        .MIN_MAX  (60),
        .HOUR_MAX (24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .send  (send),
        .hour  (hour),
        .min   (min),
        .sec   (sec),
        .msec  (msec),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line receiver: every bit must stay constant for 16 clocks, start=0, stop=1.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active  = 1;
                mon_cnt     = 0;
                mon_bits    = '0;
                mon_bits[0] = tx;
                start_cyc_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % BITC == 0) begin
                mon_bits[mon_cnt / BITC] = tx;
            end else if (tx !== mon_bits[mon_cnt / BITC]) begin
                frame_err++;
            end
            if (mon_cnt == 10 * BITC - 1) begin
                if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
                rx_q.push_back(mon_bits[8:1]);
                raw_q.push_back(mon_bits);
                mon_active = 0;
            end
        end
    end

    // Expected character i of the message for the given field values.
    function automatic logic [7:0] exp_char(input int i, input int h, input int m,
                                             input int s, input int c);
        int v;
        int mx;
        if (i == 2 || i == 5) return 8'h3A;
        if (i == 8)  return 8'h2E;
        if (i == 11) return 8'h0D;
        if (i == 12) return 8'h0A;
        case (i / 3)
            0:       begin v = h; mx = 24;  end
            1:       begin v = m; mx = 60;  end
            2:       begin v = s; mx = 60;  end
            default: begin v = c; mx = 100; end
        endcase
        if (v >= mx) return 8'h2D;
        if (i % 3 == 0) return 8'(48 + v / 10);
        return 8'(48 + v % 10);
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        raw_q.delete();
        start_cyc_q.delete();
        frame_err = 0;
    endtask

    // Pulse send with the given fields, then scramble inputs; returns at the LOAD-cycle negedge.
    task automatic start_msg(input int h, input int m, input int s, input int c);
        @(negedge clk);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
        msec = 7'(c);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        hour = 5'($urandom);
        min  = 6'($urandom);
        sec  = 6'($urandom);
        msec = 7'($urandom);
    endtask

    task automatic wait_done(input string name, output bit ok, output int dc);
        ok = 0;
        dc = 0;
        for (int i = 0; i < LEN * BYTE_CLKS + 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                dc = cyc;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done=%b, required 1 within %0d clocks",
                     name, done, LEN * BYTE_CLKS + 40);
        end
    endtask

    task automatic check_msg(input string name, input int h, input int m, input int s,
                             input int c, input int base, input int dc);
        int bad;
        n_checks++;
        if (rx_q.size() < base + LEN || start_cyc_q.size() < base + LEN) begin
            n_fail++;
            $display("FAIL %s_byte_count: got %0d bytes, required %0d",
                     name, rx_q.size() - base, LEN);
            return;
        end
        for (int i = 0; i < LEN; i++) begin
            n_checks++;
            if (rx_q[base + i] !== exp_char(i, h, m, s, c)) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h, required %h",
                         name, i, rx_q[base + i], exp_char(i, h, m, s, c));
            end
        end
        bad = 0;
        for (int k = 0; k < LEN - 1; k++) begin
            if (start_cyc_q[base + k + 1] - start_cyc_q[base + k] != BYTE_CLKS) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_byte_spacing: %0d gaps differ, required 0 (each %0d clocks)",
                     name, bad, BYTE_CLKS);
        end
        n_checks++;
        if (dc - (start_cyc_q[base] - 1) != LEN * BYTE_CLKS) begin
            n_fail++;
            $display("FAIL %s_duration: got %0d clocks, required %0d",
                     name, dc - (start_cyc_q[base] - 1), LEN * BYTE_CLKS);
        end
        n_checks++;
        if (frame_err != 0) begin
            n_fail++;
            $display("FAIL %s_framing: got %0d bit errors, required 0", name, frame_err);
        end
        $display("msg %s: h=%0d m=%0d s=%0d c=%0d bytes=%0d", name, h, m, s, c, LEN);
    endtask

    task automatic run_msg(input string name, input int h, input int m, input int s, input int c);
        bit ok;
        int dc;
        clear_mon();
        start_msg(h, m, s, c);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_rise: got %b, required 1", name, busy);
        end
        wait_done(name, ok, dc);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
        if (ok) check_msg(name, h, m, s, c, 0, dc);
    endtask

    task automatic test_reset();
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b, required 1 0 0", tx, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: tx=%b busy=%b, required 1 0", tx, busy);
        end
        $display("reset: tx=%b busy=%b done=%b", tx, busy, done);
    endtask

    task automatic test_basic();
        logic [9:0] colon_line;
        colon_line = 10'b10_0111_0100;   // line order 0,0,1,0,1,1,1,0,0,1 read from bit 0
        run_msg("basic", 12, 34, 56, 78);
        n_checks++;
        if (raw_q.size() < 3 || raw_q[2] !== colon_line) begin
            n_fail++;
            $display("FAIL colon_line_bits: got %b, required %b",
                     (raw_q.size() < 3) ? 10'h0 : raw_q[2], colon_line);
        end
    endtask

    task automatic test_zero_pad();
        run_msg("zeros", 0, 0, 0, 0);
        run_msg("pad", 5, 7, 9, 3);
    endtask

    task automatic test_out_of_range();
        run_msg("hour_oor", 30, 34, 56, 78);
        run_msg("all_oor", 24, 60, 63, 100);
        run_msg("max_ok", 23, 59, 59, 99);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            run_msg("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 127)));
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        int dc;
        clear_mon();
        start_msg(8, 21, 42, 17);
        repeat (700) @(negedge clk);
        min = 6'd55;
        hour = 5'd3;
        wait_done("snapshot", ok, dc);
        if (ok) check_msg("snapshot", 8, 21, 42, 17, 0, dc);
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int dc;
        clear_mon();
        start_msg(1, 2, 3, 4);
        repeat (300) @(negedge clk);
        hour = 5'd9;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done("ignore", ok, dc);
        repeat (2 * BYTE_CLKS) @(negedge clk);
        n_checks++;
        if (rx_q.size() != LEN || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_single_msg: bytes=%0d busy=%b, required %0d 0",
                     rx_q.size(), busy, LEN);
        end
        if (ok) check_msg("ignore", 1, 2, 3, 4, 0, dc);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int da;
        int db;
        clear_mon();
        start_msg(10, 20, 30, 40);
        wait_done("b2b_a", ok, da);
        hour = 5'd19;
        min  = 6'd48;
        sec  = 6'd7;
        msec = 7'd66;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept_in_done: busy=%b, required 1", busy);
        end
        wait_done("b2b_b", ok, db);
        check_msg("b2b_a", 10, 20, 30, 40, 0, da);
        check_msg("b2b_b", 19, 48, 7, 66, LEN, db);
        n_checks++;
        if (start_cyc_q.size() <= LEN || start_cyc_q[LEN] != da + 2) begin
            n_fail++;
            $display("FAIL b2b_no_gap: second start at %0d, required %0d",
                     (start_cyc_q.size() > LEN) ? start_cyc_q[LEN] : -1, da + 2);
        end
    endtask

    task automatic test_reset_abort();
        int guard;
        clear_mon();
        start_msg(12, 34, 56, 78);
        guard = 0;
        while (start_cyc_q.size() < 4 && guard < 5 * BYTE_CLKS) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (start_cyc_q.size() < 4) begin
            n_fail++;
            $display("FAIL abort_reach_byte3: starts=%0d, required 4", start_cyc_q.size());
        end
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: tx=%b busy=%b, required 1 0", tx, busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3 * BITC) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 3 || tx !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: bytes=%0d tx=%b done=%b, required 3 1 0",
                     rx_q.size(), tx, done);
        end
        run_msg("after_abort", 6, 5, 4, 3);
    endtask

    initial begin
        reset = 1'b1;
        send  = 1'b0;
        hour  = '0;
        min   = '0;
        sec   = '0;
        msec  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_zero_pad();
        test_out_of_range();
        test_snapshot();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_time_tx.md
# watch_time_tx

Formats a snapshot of the current watch/stopwatch time as the ASCII string "HH:MM:SS.CC" and transmits it over UART, 8N1, LSB first. It is the transmit-direction counterpart of the command decoder, which turns received UART characters into run/clear/add pulses. It sits beside the display path and takes the same hour/min/sec/msec buses that feed the FND controller. Its serial output drives the board's UART TX pin.

## Interface
- CLK_FREQ, 100_000_000: clk frequency in Hz
- BAUD, 9600: line rate; bit period BIT_CLKS = CLK_FREQ/BAUD clocks (integer division)
- MSEC_MAX, 100; SEC_MAX, 60; MIN_MAX, 60; HOUR_MAX, 24: field limits; they also set field widths via $clog2
- clk  input  1  system clock; the block uses this one clock only
- reset  input  1  asynchronous, active-high reset
- send  input  1  request; sampled on every clk edge
- hour  input  $clog2(HOUR_MAX)  hour value
- min  input  $clog2(MIN_MAX)  minute value
- sec  input  $clog2(SEC_MAX)  second value
- msec  input  $clog2(MSEC_MAX)  centisecond value
- tx  output  1  serial line; idle high
- busy  output  1  high from the cycle after a request is accepted until the message is complete
- done  output  1  one-cycle pulse when the last stop bit completes

## Operation
- Reset values: tx=1, busy=0, done=0, FSM in IDLE, all counters 0.
- Request accept: a request is accepted when send=1 and busy=0.
  - All four fields are captured into snapshot registers on that edge.
  - Later input changes do not affect the message in flight.
- send while busy=1 is ignored. Requests are not queued.
- Message bytes, in order: H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0.
  - Optionally followed by CR, LF (see Configuration).
- Digit conversion per field v:
  - tens = v/10, units = v%10, using compare/subtract logic (no divider IP).
  - Each digit is sent as 8'h30+digit.
- Out-of-range field: if v ≥ the field's *_MAX, both of its digits are sent as '-' (8'h2D).
- Frame per byte: start bit 0, then data bits d0..d7, then stop bit 1. Each bit is held exactly BIT_CLKS clocks.
- Bytes are sent back-to-back with no idle gap: the stop bit of byte n is followed immediately by the start bit of byte n+1.
- FSM states:
  - IDLE: on accept -> LOAD.
  - LOAD: one cycle; selects byte[idx] -> START.
  - START: after BIT_CLKS -> DATA.
  - DATA: after 8×BIT_CLKS -> STOP.
  - STOP: after BIT_CLKS -> LOAD if idx < LEN-1 (idx increments), else -> IDLE and pulse done.
- Reset asserted mid-frame: the frame is aborted immediately; tx=1 and busy=0 in the same cycle. No partial stop bit is sent.

## Timing
- Accept at edge E:
  - busy=1 from E+1.
  - LOAD occupies cycle E+1.
  - tx falls (start bit) at E+2.
- Byte duration: 10×BIT_CLKS + 1 clocks, where the +1 is the LOAD cycle.
- Message duration: LEN×(10×BIT_CLKS+1) clocks from the first LOAD to the done pulse.
- done is high for exactly one cycle. busy falls on the same edge that done rises. A new request is acceptable on the cycle after that edge.
- send coinciding with the done cycle is accepted, because busy is already 0.
- tx is registered: no combinational path from inputs to tx.

## Configuration
- WATCH_TX_CRLF_EN defined: LEN=13; CR (8'h0D) and LF (8'h0A) are appended after C0.
- Macro undefined: LEN=11; the message ends at C0.

## Structure
- Shared package watch_pkg holds:
  - ASCII constants: ZERO 8'h30, COLON 8'h3A, DOT 8'h2E, DASH 8'h2D, CR, LF.
  - Message-length constants.
  - The FSM state enum.
- One sub-module, uart_tx_byte. It contains the baud counter and bit serializer.
  - Interface: start/data[7:0] in; tx/busy/done out.
  - The top level holds the snapshot registers, the digit formatter, the byte index and the message FSM.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1, so BIT_CLKS=16.
- Basic: hour=12, min=34, sec=56, msec=78, pulse send.
  - Required: the decoded bytes are "12:34:56.78" (plus CR LF with the macro defined).
  - Required: done arrives 11×161 clocks after the first LOAD without the macro, 13×161 with it.
- Zero padding: all fields 0, or hour=5, min=7.
  - Required: "00:00:00.00" and "05:07:…" respectively.
- Out of range: hour=30 with HOUR_MAX=24.
  - Required: the string starts "--:".
  - Required: all other fields are correct.
- Snapshot and ignore:
  - Change min mid-message: the transmitted string is unchanged.
  - Pulse send while busy: exactly one message is sent.
  - Pulse send in the done cycle: a second message starts with no gap.
- Reset abort: assert reset during DATA of byte 3.
  - Required: tx=1, busy=0 immediately.
  - Required: after release, a new send produces a clean full message.
- Frame check: measure the start-bit falling edge to the stop-bit end.
  - Required: exactly 160 clocks per frame.
  - Required: bits are sent LSB first; ':' appears on the line as 0,0,1,0,1,1,1,0,0,1.
